// File: rtl/add_image_blend_sat_pipe_pkg.sv
// Shared widths, frame geometry defaults and the saturating shift used by
// every colour channel of the blend pipeline.
package add_image_pkg;

    localparam int PROD_W = 16;
    localparam int PIX_W  = 8;
    localparam int FRAC_W = 8;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int CNT_W  = 11;

    // Two guard bits: the sum of two signed products plus the rounding
    // constant cannot overflow this width.
    localparam int SUM_W = PROD_W + 2;

    localparam logic [SUM_W-1:0] RND_C   = SUM_W'(1) << (FRAC_W - 1);
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    // Arithmetic shift by FRAC_W, then clamp into the unsigned pixel range.
    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] q;
        q = sum >>> FRAC_W;
        if (q < 0) begin
            return '0;
        end else if (q > $signed(SUM_W'(PIX_MAX))) begin
            return PIX_MAX;
        end else begin
            return q[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/add_image_blend_sat_pipe_if.sv
// Product input stream and pixel output stream of the blend stage.
// master = the side that supplies products and consumes pixels,
// slave  = the blend stage itself.
interface add_image_blend_sat_pipe_if;
    import add_image_pkg::*;

    logic [3*PROD_W-1:0] s_prod_a;
    logic [3*PROD_W-1:0] s_prod_b;
    logic                s_valid;
    logic                s_ready;
    logic [3*PIX_W-1:0]  m_pix;
    logic                m_valid;
    logic                m_ready;
    logic                m_user;
    logic                m_last;
    logic                frame_done;

    modport master (
        output s_prod_a, s_prod_b, s_valid, m_ready,
        input  s_ready, m_pix, m_valid, m_user, m_last, frame_done
    );

    modport slave (
        input  s_prod_a, s_prod_b, s_valid, m_ready,
        output s_ready, m_pix, m_valid, m_user, m_last, frame_done
    );

endinterface

// File: rtl/add_image_blend_sat_pipe_blend_ch.sv
// One colour channel: S1 adds the two weighted products plus the rounding
// constant, S2 shifts and saturates to a pixel. Both stages load on en.
module add_image_blend_ch
    import add_image_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PROD_W-1:0] a,
    input  logic [PROD_W-1:0] b,
    output logic [PIX_W-1:0]  pix
);

    logic signed [SUM_W-1:0] sum_q;

    // S1 rounded sum and S2 saturated pixel, both frozen while stalled.
    // NOTE: the datapath registers are reset as well so the pixel bus reads
    // zero during reset; non-blocking updates keep S2 reading the old S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            pix   <= '0;
        end else if (en) begin
            sum_q <= {{2{a[PROD_W-1]}}, a} + {{2{b[PROD_W-1]}}, b} + RND_C;
            pix   <= sat_pix(sum_q);
        end
    end

endmodule

// File: rtl/add_image_blend_sat_pipe.sv
// Blend/saturate stage of the acoustic-camera overlay: three channel
// datapaths, a two-deep valid pipeline with backpressure, raster counters
// producing SOF/EOL tags and an end-of-frame pulse.
module add_image_blend_sat_pipe #(
    parameter int IMG_W = add_image_pkg::IMG_W,
    parameter int IMG_H = add_image_pkg::IMG_H,
    parameter int CNT_W = add_image_pkg::CNT_W
) (
    input logic                       ap_clk,
    input logic                       ap_rst,
    add_image_blend_sat_pipe_if.slave bus
);
    import add_image_pkg::*;

    logic             adv;
    logic             hs;
    logic             s1_valid;
    logic             s2_valid;
    logic             x_end;
    logic             y_end;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [3*PIX_W-1:0] pix;

    // NOTE: s_ready is a combinational function of m_ready; with no skid
    // buffer the whole pipe freezes in the same cycle downstream stalls.
    assign adv         = !s2_valid || bus.m_ready;
    assign bus.s_ready = adv && !ap_rst;
    assign hs          = s2_valid && bus.m_ready;

    assign x_end = (x == CNT_W'(IMG_W - 1));
    assign y_end = (y == CNT_W'(IMG_H - 1));

    // Counters describe the beat sitting in S2, so the tags are stable
    // for as long as that beat is held.
    assign bus.m_valid = s2_valid;
    assign bus.m_user  = s2_valid && (x == '0) && (y == '0);
    assign bus.m_last  = s2_valid && x_end;
    assign bus.m_pix   = pix;

    // Valid bits shift one stage per advance; bubbles travel as zeros.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.s_valid;
            s2_valid <= s1_valid;
        end
    end

    // Raster position of the output beat, stepped on each output handshake.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            x <= '0;
            y <= '0;
        end else if (hs) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // One-cycle pulse after the final pixel of the frame leaves.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= hs && x_end && y_end;
        end
    end

    // Channel 2 (R) sits in the MSBs, channel 0 (B) in the LSBs.
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        add_image_blend_ch u_ch (
            .clk (ap_clk),
            .rst (ap_rst),
            .en  (adv),
            .a   (bus.s_prod_a[ch*PROD_W +: PROD_W]),
            .b   (bus.s_prod_b[ch*PROD_W +: PROD_W]),
            .pix (pix[ch*PIX_W +: PIX_W])
        );
    end

endmodule
